// File: rtl/ffram_port_arbiter.sv
// Purpose : shares port 0 of a dual-port flip-flop RAM between host single-word accesses and a fill engine.
// Latency : grant is combinational; host read data returns one cycle after acceptance (host_rdata_valid pulse).
// Backpressure: host_ready low when the fill wins a contended cycle; round-robin on contention.
//               With FFRAM_ARB_HOST_LOCKOUT_EN defined the fill owns the port for its whole duration.
// Ports   : clk/reset (sync, active-high); host_* request/response; fill_* control/status;
//           ram_*0 drive the RAM read/write port (ram_rdata0 is registered, 1-cycle latency).
module ffram_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_valid,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ready,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rdata_valid,
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH:0]   fill_count,
    input  logic [DATA_WIDTH-1:0] fill_value,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] ram_addr0,
    output logic [DATA_WIDTH-1:0] ram_wdata0,
    output logic                  ram_we0,
    input  logic [DATA_WIDTH-1:0] ram_rdata0
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic                  last_fill_q;   // 1: fill won the previous contended cycle
    logic                  done_q;
    logic                  done_nxt;
    logic                  rvld_q;
    logic [ADDR_WIDTH-1:0] addr_q;        // last driven port-0 address, held when idle
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  host_req;
    logic                  fill_req;
    logic                  contended;
    logic                  grant_host;
    logic                  grant_fill;
    logic                  last_write;
    logic                  fill_accept;
    logic [ADDR_WIDTH-1:0] fill_addr;

    // Requests are masked during reset so an in-flight fill stops writing in the reset cycle itself.
    assign fill_req = (state == FILL) && !reset;
`ifdef FFRAM_ARB_HOST_LOCKOUT_EN
    assign host_req = host_valid && !reset && (state != FILL);
`else
    assign host_req = host_valid && !reset;
`endif

    assign contended   = host_req && fill_req;
    assign grant_host  = host_req && (!fill_req || last_fill_q);
    assign grant_fill  = fill_req && (!host_req || !last_fill_q);
    assign fill_addr   = base_q + idx_q[ADDR_WIDTH-1:0];
    assign last_write  = (idx_q == count_q - 1'b1);
    assign fill_accept = (state == IDLE) && fill_start && (fill_count != '0);

    assign host_ready       = grant_host;
    assign host_rdata       = ram_rdata0;
    assign host_rdata_valid = rvld_q;
    assign fill_busy        = (state == FILL);
    assign fill_done        = done_q;

    // Port-0 mux; with no grant the address/data buses hold their previous values.
    always_comb begin
        ram_addr0  = addr_q;
        ram_wdata0 = wdata_q;
        ram_we0    = 1'b0;
        if (grant_host) begin
            ram_addr0  = host_addr;
            ram_wdata0 = host_wdata;
            ram_we0    = host_we;
        end else if (grant_fill) begin
            ram_addr0  = fill_addr;
            ram_wdata0 = value_q;
            ram_we0    = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state; a zero-length fill completes without leaving IDLE.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    if (fill_count != '0) begin
                        state_nxt = FILL;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            FILL: begin
                if (grant_fill && last_write) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            value_q     <= '0;
            last_fill_q <= 1'b1;
            done_q      <= 1'b0;
            rvld_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            done_q <= done_nxt;
            rvld_q <= grant_host && !host_we;
            if (fill_accept) begin
                base_q  <= fill_base;
                count_q <= fill_count;
                value_q <= fill_value;
                idx_q   <= '0;
            end else if (grant_fill) begin
                idx_q <= idx_q + 1'b1;
            end
            // Fairness history only moves on cycles where both sides wanted the port.
            if (contended) begin
                last_fill_q <= grant_fill;
            end
            if (grant_host || grant_fill) begin
                addr_q  <= ram_addr0;
                wdata_q <= ram_wdata0;
            end
        end
    end

endmodule

// File: tb/tb_ffram_port_arbiter.sv
module tb_ffram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_valid, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ready;
    logic [DW-1:0] host_rdata;
    logic          host_rdata_valid;
    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_count;
    logic [DW-1:0] fill_value;
    logic          fill_busy, fill_done;
    logic [AW-1:0] ram_addr0;
    logic [DW-1:0] ram_wdata0;
    logic          ram_we0;
    logic [DW-1:0] ram_rdata0 = '0;

    ffram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
        .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count), .fill_value(fill_value),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_addr0(ram_addr0), .ram_wdata0(ram_wdata0), .ram_we0(ram_we0), .ram_rdata0(ram_rdata0)
    );

    always #5 clk = ~clk;

    // Behavioural RAM port 0: registered read, read-before-write.
    logic [DW-1:0] mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we0) mem[ram_addr0] <= ram_wdata0;
        ram_rdata0 <= mem[ram_addr0];
    end

    // Bench's own view of RAM contents, built from the stimulus it issues.
    logic [DW-1:0] exp_mem [256] = '{default: '0};
    logic [DW-1:0] sb_q [$];
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];

    int n_vec = 0;
    int n_bad = 0;
    int done_n = 0;

    logic          s_ready, s_we, s_busy, s_done, s_rvld;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at negedge, run the scoreboard, return just after the next posedge.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        s_ready = host_ready; s_we = ram_we0; s_addr = ram_addr0; s_wdata = ram_wdata0;
        s_busy = fill_busy; s_done = fill_done; s_rvld = host_rdata_valid;
        if (host_rdata_valid) begin
            chk("rvld_has_request", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("host_rdata", host_rdata, e);
            end
        end
        if (host_ready && !host_we) sb_q.push_back(exp_mem[host_addr]);
        if (host_ready && host_we) exp_mem[host_addr] = host_wdata;
        if (ram_we0) begin
            wa_q.push_back(ram_addr0);
            wd_q.push_back(ram_wdata0);
        end
        if (fill_done) done_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic host_read(input logic [AW-1:0] a, input string tag);
        host_valid = 1'b1; host_we = 1'b0; host_addr = a;
        tick();
        chk(tag, s_ready, 1);
    endtask

    task automatic pulse_fill(input logic [AW-1:0] b, input logic [AW:0] c, input logic [DW-1:0] v);
        fill_base = b; fill_count = c; fill_value = v; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    initial begin
        int d0;
        int done_cyc;
        logic [AW-1:0] ra;
        logic [AW-1:0] ea;

        reset = 1'b1; host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
        tick(); tick();
        chk("rst_busy", s_busy, 0);
        chk("rst_done", s_done, 0);
        chk("rst_rvld", s_rvld, 0);
        chk("rst_we", s_we, 0);
        reset = 1'b0;
        tick();
        chk("idle_ready", s_ready, 0);

        // Host write then read back
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 16'h1234;
        tick();
        chk("wr_ready", s_ready, 1);
        chk("wr_we", s_we, 1);
        chk("wr_addr", s_addr, 8'h10);
        host_read(8'h10, "rd_ready");
        chk("rd_we", s_we, 0);
        host_valid = 1'b0;
        tick();
        chk("rd_rvld_n1", s_rvld, 1);
        tick();
        chk("rd_rvld_pulse", s_rvld, 0);

        // Uncontended fill of 8 words
        d0 = done_n;
        pulse_fill(8'h20, 9'd8, 16'hABCD);
        chk("f8_start_we", s_we, 0);
        chk("f8_start_busy", s_busy, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("f8_busy", s_busy, 1);
            chk("f8_we", s_we, 1);
            chk("f8_addr", s_addr, 32'h20 + i);
            chk("f8_wdata", s_wdata, 16'hABCD);
        end
        tick();
        chk("f8_done", s_done, 1);
        chk("f8_busy_drop", s_busy, 0);
        chk("f8_we_drop", s_we, 0);
        tick();
        chk("f8_done_pulses", done_n - d0, 1);
        for (int i = 0; i < 8; i++) exp_mem[8'h20 + i] = 16'hABCD;
        for (int i = 0; i < 9; i++) host_read(8'(8'h20 + i), "f8_rb_ready");
        host_valid = 1'b0;
        tick(); tick();

        // Fill of 6 with continuous host reads: strict alternation, host first
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        pulse_fill(8'h40, 9'd6, 16'h5A5A);
        chk("rr_c0_ready", s_ready, 1);
        ra = 8'h21;
        done_cyc = 0;
        for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
            host_addr = ra;
            tick();
            if (c <= 12) begin
                chk("rr_host_grant", s_ready, 32'(c % 2));
                chk("rr_fill_we", s_we, 32'((c + 1) % 2));
                if (c % 2 == 0) chk("rr_fill_addr", s_addr, 32'h40 + c / 2 - 1);
            end
            if (s_done) done_cyc = c;
            if (s_ready) ra = 8'h20 + ((ra - 8'h20 + 8'd1) & 8'h07);
        end
        chk("rr_done_cycle", done_cyc, 13);
        host_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 6; i++) exp_mem[8'h40 + i] = 16'h5A5A;
        host_read(8'h40, "rr_rb_ready");
        host_read(8'h45, "rr_rb_ready");
        host_read(8'h46, "rr_rb_ready");
        host_valid = 1'b0;
        tick(); tick();

        // Address wrap
        wa_q.delete(); wd_q.delete();
        d0 = done_n;
        pulse_fill(8'hFE, 9'd4, 16'h1111);
        for (int i = 0; i < 10 && done_n == d0; i++) tick();
        chk("wrap_done", done_n - d0, 1);
        chk("wrap_nwrites", wa_q.size(), 4);
        for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
            ea = 8'hFE + 8'(i);
            chk("wrap_addr", wa_q[i], ea);
            chk("wrap_data", wd_q[i], 16'h1111);
        end
        for (int i = 0; i < 4; i++) exp_mem[8'(8'hFE + i)] = 16'h1111;
        host_read(8'hFF, "wrap_rb_ready");
        host_read(8'h01, "wrap_rb_ready");
        host_valid = 1'b0;
        tick(); tick();

        // Zero-length fill
        wa_q.delete(); wd_q.delete();
        d0 = done_n;
        pulse_fill(8'h60, 9'd0, 16'hFFFF);
        chk("z_start_we", s_we, 0);
        tick();
        chk("z_done", s_done, 1);
        chk("z_busy", s_busy, 0);
        chk("z_we", s_we, 0);
        tick();
        chk("z_done_pulse", s_done, 0);
        chk("z_nwrites", wa_q.size(), 0);
        chk("z_done_count", done_n - d0, 1);

        // Reset after 3 writes of a 10-word fill
        wa_q.delete(); wd_q.delete();
        d0 = done_n;
        pulse_fill(8'h80, 9'd10, 16'h7777);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        chk("rm_rst_we", s_we, 0);
        reset = 1'b0;
        tick();
        chk("rm_busy", s_busy, 0);
        tick(); tick();
        chk("rm_no_done", done_n - d0, 0);
        chk("rm_nwrites", wa_q.size(), 3);
        for (int i = 0; i < 3; i++) exp_mem[8'h80 + i] = 16'h7777;
        for (int i = 0; i < 4; i++) host_read(8'(8'h80 + i), "rm_rb_ready");
        host_valid = 1'b0;
        tick(); tick();

`ifdef FFRAM_ARB_HOST_LOCKOUT_EN
        // Host locked out for the whole fill
        pulse_fill(8'h90, 9'd4, 16'h4242);
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lk_ready", s_ready, 0);
            chk("lk_we", s_we, 1);
            chk("lk_busy", s_busy, 1);
        end
        tick();
        chk("lk_busy_drop", s_busy, 0);
        chk("lk_done", s_done, 1);
        chk("lk_host_accept", s_ready, 1);
        host_valid = 1'b0;
        tick(); tick();
`endif

        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
